rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_pkg.sv | 11 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rf_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path.
// Holds the queued-write entry layout used by the arbiter and its FIFO.
package rf_pkg;
   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] ind;
      logic [XLEN-1:0]      dat;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue: circular buffer with up to two pushes and one pop
// per cycle, exposing per-entry valid and index for hazard matching.
module wb_fifo
   import rf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push0,
   input  wb_entry_t                       d0,
   input  logic                            push1,
   input  wb_entry_t                       d1,
   input  logic                            pop,
   output wb_entry_t                       head,
   output logic [CW-1:0]                   count,
   output logic [DEPTH-1:0]                valid,
   output logic [DEPTH-1:0][REG_IDX_W-1:0] ind,
   output logic [PW-1:0]                   rd_ptr
);

   wb_entry_t          mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      wr_nxt;
   logic [DEPTH-1:0]   valid_nxt;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_nxt = inc(wr_ptr);
   assign head   = mem_q[rd_ptr];

   always_comb begin
      valid_nxt = valid;
      if (pop)   valid_nxt[rd_ptr] = 1'b0;
      if (push0) valid_nxt[wr_ptr] = 1'b1;
      if (push1) valid_nxt[wr_nxt] = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ind[i] = mem_q[i].ind;
   end

   always_ff @(posedge clk) begin
      if (push0) mem_q[wr_ptr] <= d0;
      if (push1) mem_q[wr_nxt] <= d1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (push1)      wr_ptr <= inc(wr_nxt);
         else if (push0) wr_ptr <= wr_nxt;
         if (pop) rd_ptr <= inc(rd_ptr);
         count <= count + CW'(push0) + CW'(push1) - CW'(pop);
         valid <= valid_nxt;
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// Serialises load and ALU writebacks onto one register-file write port,
// buffering collisions in order and flagging read-after-write hazards.
module rf_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = rf_pkg::XLEN
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_take,
   input  logic [4:0]      alu_ind,
   input  logic [XLEN-1:0] alu_dat,
   input  logic            mem_take,
   input  logic [4:0]      mem_ind,
   input  logic [XLEN-1:0] mem_dat,
   input  logic [4:0]      rs1_ind,
   input  logic [4:0]      rs2_ind,
   output logic            wr_en,
   output logic [4:0]      wr_ind,
   output logic [XLEN-1:0] wr_dat,
   output logic            stall,
   output logic            rs1_pend,
   output logic            rs2_pend,
   output logic            overflow_err
);
   import rf_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic                            m_v, a_v, q_ne, pop;
   logic                            m_enq, a_enq;
   logic                            c0_v, c1_v, push0, push1, drop;
   wb_entry_t                       m_e, a_e, c0, head;
   logic [CW-1:0]                   count, space;
   logic [DEPTH-1:0]                q_valid, live;
   logic [DEPTH-1:0][REG_IDX_W-1:0] q_ind;
   logic [PW-1:0]                   rd_ptr;

   // x0 writes are dropped at the door; reset also masks arrivals
   assign m_v  = rst_n && mem_take && (mem_ind != '0);
   assign a_v  = rst_n && alu_take && (alu_ind != '0);
   assign m_e  = '{ind: mem_ind, dat: mem_dat};
   assign a_e  = '{ind: alu_ind, dat: alu_dat};
   assign q_ne = (count != '0);
   assign pop  = q_ne;

   assign m_enq = m_v && q_ne;
   assign a_enq = a_v && (q_ne || m_v);
   assign c0_v  = m_enq || a_enq;
   assign c1_v  = m_enq && a_enq;
   assign c0    = m_enq ? m_e : a_e;

   // the slot freed by this cycle's pop is not counted as space
   assign space = CW'(DEPTH) - count;
   assign push0 = c0_v && (space != '0);
   assign push1 = c1_v && (space >= CW'(2));
   assign drop  = (c0_v && !push0) || (c1_v && !push1);
   assign stall = (count >= CW'(DEPTH - 1));

   always_comb begin
      wr_en  = 1'b1;
      wr_ind = '0;
      wr_dat = '0;
      priority case (1'b1)
         q_ne: begin
            wr_ind = head.ind;
            wr_dat = head.dat;
         end
         m_v: begin
            wr_ind = mem_ind;
            wr_dat = mem_dat;
         end
         a_v: begin
            wr_ind = alu_ind;
            wr_dat = alu_dat;
         end
         default: wr_en = 1'b0;
      endcase
   end

   always_comb begin
      rs1_pend = 1'b0;
      rs2_pend = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = q_valid[i] && !(pop && (PW'(i) == rd_ptr));
         if (live[i] && (q_ind[i] == rs1_ind)) rs1_pend = 1'b1;
         if (live[i] && (q_ind[i] == rs2_ind)) rs2_pend = 1'b1;
      end
      if (m_enq && (mem_ind == rs1_ind)) rs1_pend = 1'b1;
      if (a_enq && (alu_ind == rs1_ind)) rs1_pend = 1'b1;
      if (m_enq && (mem_ind == rs2_ind)) rs2_pend = 1'b1;
      if (a_enq && (alu_ind == rs2_ind)) rs2_pend = 1'b1;
      if (rs1_ind == '0) rs1_pend = 1'b0;
      if (rs2_ind == '0) rs2_pend = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow_err <= 1'b0;
      else if (drop) overflow_err <= 1'b1;
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push0  (push0),
      .d0     (c0),
      .push1  (push1),
      .d1     (a_e),
      .pop    (pop),
      .head   (head),
      .count  (count),
      .valid  (q_valid),
      .ind    (q_ind),
      .rd_ptr (rd_ptr)
   );
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued at
// drive time and retired against the write port on each falling edge.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_take = 1'b0, mem_take = 1'b0;
   logic [4:0]  alu_ind = '0, mem_ind = '0, rs1_ind = '0, rs2_ind = '0;
   logic [31:0] alu_dat = '0, mem_dat = '0;
   logic        wr_en, stall, rs1_pend, rs2_pend, overflow_err;
   logic [4:0]  wr_ind;
   logic [31:0] wr_dat;

   int n_chk = 0;
   int n_fail = 0;
   wb_entry_t sb[$];

   always #5 clk = ~clk;

   rf_write_arbiter #(.DEPTH(4), .XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_take     (alu_take),
      .alu_ind      (alu_ind),
      .alu_dat      (alu_dat),
      .mem_take     (mem_take),
      .mem_ind      (mem_ind),
      .mem_dat      (mem_dat),
      .rs1_ind      (rs1_ind),
      .rs2_ind      (rs2_ind),
      .wr_en        (wr_en),
      .wr_ind       (wr_ind),
      .wr_dat       (wr_dat),
      .stall        (stall),
      .rs1_pend     (rs1_pend),
      .rs2_pend     (rs2_pend),
      .overflow_err (overflow_err)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic mt, input logic [4:0] mi,
                        input logic [31:0] md, input logic at,
                        input logic [4:0] ai, input logic [31:0] ad);
      mem_take = mt; mem_ind = mi; mem_dat = md;
      alu_take = at; alu_ind = ai; alu_dat = ad;
   endtask

   task automatic expect_wr(input logic [4:0] i, input logic [31:0] d);
      sb.push_back('{ind: i, dat: d});
   endtask

   task automatic half();
      wb_entry_t e;
      @(negedge clk);
      if (wr_en) begin
         if (sb.size() == 0) begin
            check("spurious_wr", wr_en, 1'b0);
         end else begin
            e = sb.pop_front();
            check("wr_ind", wr_ind, e.ind);
            check("wr_dat", wr_dat, e.dat);
         end
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         half();
         edge_();
      end
      check("drain_left", sb.size(), 0);
      half();
      check("idle_wr_en", wr_en, 1'b0);
      edge_();
   endtask

   initial begin
      // reset state, with a take asserted that must be ignored
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
      rs1_ind = 5'd6;
      @(negedge clk);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_rs1_pend", rs1_pend, 1'b0);
      check("rst_ovf", overflow_err, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rs1_ind = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      edge_();

      // single ALU write, same-cycle issue
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA0001);
      expect_wr(5'd5, 32'hAAAA0001);
      half();
      check("single_wr_en", wr_en, 1'b1);
      check("single_stall", stall, 1'b0);
      edge_();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      half();
      check("single_no_queue", wr_en, 1'b0);
      edge_();

      // collision: mem first, alu next cycle
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
      rs2_ind = 5'd7;
      expect_wr(5'd3, 32'h11);
      expect_wr(5'd7, 32'h22);
      half();
      check("coll_rs2_pend_c0", rs2_pend, 1'b1);
      edge_();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      half();
      check("coll_wr_en_c1", wr_en, 1'b1);
      check("coll_rs2_pend_c1", rs2_pend, 1'b0);
      edge_();
      rs2_ind = '0;
      drain();

      // x0 filter
      drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd9, 32'h10);
      expect_wr(5'd9, 32'h10);
      half();
      check("x0_wr_en", wr_en, 1'b1);
      check("x0_rs1_pend", rs1_pend, 1'b0);
      edge_();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drain();

      // same index twice
      drive(1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
      rs1_ind = 5'd4;
      expect_wr(5'd4, 32'h1);
      expect_wr(5'd4, 32'h2);
      half();
      check("same_rs1_pend_c0", rs1_pend, 1'b1);
      edge_();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      half();
      check("same_rs1_pend_c1", rs1_pend, 1'b0);
      edge_();
      rs1_ind = '0;
      drain();

      // backpressure: four arrival cycles, last alu is dropped
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 5'(10 + 2 * c), 32'(32'h100 + c),
               1'b1, 5'(11 + 2 * c), 32'(32'h200 + c));
         expect_wr(5'(10 + 2 * c), 32'(32'h100 + c));
         if (c < 3) expect_wr(5'(11 + 2 * c), 32'(32'h200 + c));
         half();
         check($sformatf("bp_stall_c%0d", c), stall, (c == 3));
         check($sformatf("bp_ovf_c%0d", c), overflow_err, 1'b0);
         edge_();
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      half();
      check("bp_ovf_set", overflow_err, 1'b1);
      check("bp_stall_after", stall, 1'b1);
      edge_();
      drain();
      check("bp_ovf_sticky", overflow_err, 1'b1);

      // reset with two writes queued
      drive(1'b1, 5'd1, 32'h31, 1'b1, 5'd2, 32'h32);
      expect_wr(5'd1, 32'h31);
      half();
      edge_();
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h38);
      expect_wr(5'd2, 32'h32);
      half();
      edge_();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rs1_ind = 5'd8;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr_en", wr_en, 1'b0);
      check("rst_mid_stall", stall, 1'b0);
      check("rst_mid_pend", rs1_pend, 1'b0);
      check("rst_mid_ovf", overflow_err, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      edge_();
      for (int i = 0; i < 3; i++) begin
         half();
         check($sformatf("rst_stale_c%0d", i), wr_en, 1'b0);
         edge_();
      end
      check("rst_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
